// File: rtl/spi_sched_pkg.sv
// Shared types and helpers for the SPI transfer scheduler.
//   sched_state_e : scheduler FSM states
//   MAX_REQ       : upper bound on the number of requesters
//   onehot()      : index to one-hot vector (MAX_REQ bits, truncate at use site)
package spi_sched_pkg;

   localparam int MAX_REQ = 8;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LOAD,
      SEND,
      WAIT,
      DONE
   } sched_state_e;

   function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req        : level requests, one bit per requester
//   last_grant : index of the previously served requester
//   winner     : first requesting index strictly after last_grant (wrapping)
//   any        : at least one request is pending
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [IDX_W-1:0] winner,
   output logic             any
);

   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      any    = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_grant) + k) % N_REQ;
         if (!any && req[idx]) begin
            winner = IDX_W'(idx);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Round-robin burst scheduler in front of a single SPI master controller.
// One requester is granted at a time; chip-select stays low for its whole
// burst while TX bytes are fed one by one and RX bytes are routed back.
// Optional build macro: SPI_SCHED_TIMEOUT_EN adds the WAIT watchdog and the
// err output.
// Ports:
//   clk, rst                       : clock, async active-low reset
//   req, req_len, req_tx_data      : per-requester request, burst length, TX byte
//   grant, byte_ack, rx_valid, done: per-requester handshake (one-hot)
//   rx_byte                        : received byte, valid with rx_valid
//   ss_n, spi_send, spi_tx_byte    : to SPI controller
//   spi_ready, spi_rx_dv, spi_rx_byte : from SPI controller
//   err (optional)                 : watchdog abort, pulses with done
//
// state | meaning
// IDLE  | no burst, wait for any request
// ARB   | pick winner, latch length, raise grant / drop ss_n
// LOAD  | latch winner's current TX byte
// SEND  | strobe spi_send once the controller is ready
// WAIT  | wait for the received byte
// DONE  | pulse done, release grant and ss_n
module spi_xfer_scheduler
   import spi_sched_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LEN_W-1:0] req_len,
   input  logic [N_REQ*8-1:0]     req_tx_data,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       byte_ack,
   output logic [7:0]             rx_byte,
   output logic [N_REQ-1:0]       rx_valid,
   output logic [N_REQ-1:0]       done,
`ifdef SPI_SCHED_TIMEOUT_EN
   output logic [N_REQ-1:0]       err,
`endif
   output logic                   ss_n,
   output logic                   spi_send,
   output logic [7:0]             spi_tx_byte,
   input  logic                   spi_ready,
   input  logic                   spi_rx_dv,
   input  logic [7:0]             spi_rx_byte
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   sched_state_e     state_q, state_d;
   logic [IDX_W-1:0] win_q, last_grant_q, arb_idx;
   logic             arb_any;
   logic [LEN_W-1:0] len_q, byte_cnt_q, arb_len;
   logic [N_REQ-1:0] win_oh, arb_oh;
   logic             rx_last;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req        (req),
      .last_grant (last_grant_q),
      .winner     (arb_idx),
      .any        (arb_any)
   );

   assign win_oh  = N_REQ'(onehot(32'(win_q)));
   assign arb_oh  = N_REQ'(onehot(32'(arb_idx)));
   assign arb_len = req_len[arb_idx*LEN_W +: LEN_W];
   assign rx_last = (byte_cnt_q == len_q - LEN_W'(1));

`ifdef SPI_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] wait_cnt_q;
   logic            timed_out_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q  <= '0;
         timed_out_q <= 1'b0;
      end else begin
         if (state_q == SEND && spi_ready)
            wait_cnt_q <= '0;
         else if (state_q == WAIT)
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
         if (state_q == ARB)
            timed_out_q <= 1'b0;
         else if (state_q == WAIT && !spi_rx_dv && wait_cnt_q == TO_LAST)
            timed_out_q <= 1'b1;
      end
   end

   assign err = timed_out_q ? done : '0;
`endif

   always_comb begin
      state_d  = state_q;
      spi_send = 1'b0;
      byte_ack = '0;
      done     = '0;
      unique case (state_q)
         IDLE: if (|req) state_d = ARB;
         ARB:  state_d = arb_any ? LOAD : IDLE;
         LOAD: state_d = SEND;
         SEND: begin
            if (spi_ready) begin
               spi_send = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            // Received data takes priority over a watchdog expiry in the same cycle.
            if (spi_rx_dv) begin
               if (rx_last) begin
                  state_d = DONE;
               end else begin
                  byte_ack = win_oh;
                  state_d  = LOAD;
               end
            end
`ifdef SPI_SCHED_TIMEOUT_EN
            else if (wait_cnt_q == TO_LAST) begin
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            done    = win_oh;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         grant        <= '0;
         ss_n         <= 1'b1;
         spi_tx_byte  <= '0;
         rx_byte      <= '0;
         rx_valid     <= '0;
         win_q        <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);
         len_q        <= '0;
         byte_cnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         rx_valid <= '0;
         case (state_q)
            ARB: begin
               if (arb_any) begin
                  win_q      <= arb_idx;
                  len_q      <= (arb_len == '0) ? LEN_W'(1) : arb_len;
                  grant      <= arb_oh;
                  ss_n       <= 1'b0;
                  byte_cnt_q <= '0;
               end
            end
            LOAD: spi_tx_byte <= req_tx_data[win_q*8 +: 8];
            WAIT: begin
               if (spi_rx_dv) begin
                  rx_byte  <= spi_rx_byte;
                  rx_valid <= win_oh;
                  if (!rx_last)
                     byte_cnt_q <= byte_cnt_q + LEN_W'(1);
               end
            end
            DONE: begin
               grant        <= '0;
               ss_n         <= 1'b1;
               byte_cnt_q   <= '0;
               last_grant_q <= win_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Self-checking bench for spi_xfer_scheduler (N_REQ=2, LEN_W=4).
// A background process plays the requesters and the SPI controller and logs
// what the scheduler does; each session's expectations come from a
// round-robin burst model built before the session starts.
module tb_spi_xfer_scheduler;
   localparam int N_REQ = 2;
   localparam int LEN_W = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [N_REQ-1:0]       req = '0;
   logic [N_REQ*LEN_W-1:0] req_len = '0;
   logic [N_REQ*8-1:0]     req_tx_data = '0;
   logic [N_REQ-1:0]       grant, byte_ack, rx_valid, done;
   logic [7:0]             rx_byte, spi_tx_byte;
   logic                   ss_n, spi_send;
   logic                   spi_ready = 1'b0;
   logic                   spi_rx_dv = 1'b0;
   logic [7:0]             spi_rx_byte = '0;
`ifdef SPI_SCHED_TIMEOUT_EN
   logic [N_REQ-1:0]       err;
   logic [N_REQ-1:0]       last_err = '0;
`endif

   spi_xfer_scheduler #(
      .N_REQ       (N_REQ),
      .LEN_W       (LEN_W),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_len     (req_len),
      .req_tx_data (req_tx_data),
      .grant       (grant),
      .byte_ack    (byte_ack),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .done        (done),
`ifdef SPI_SCHED_TIMEOUT_EN
      .err         (err),
`endif
      .ss_n        (ss_n),
      .spi_send    (spi_send),
      .spi_tx_byte (spi_tx_byte),
      .spi_ready   (spi_ready),
      .spi_rx_dv   (spi_rx_dv),
      .spi_rx_byte (spi_rx_byte)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // environment state
   logic [1:0] req_on = '0;
   int         len_cfg[2] = '{0, 0};
   int         nb_left[2] = '{0, 0};
   int         burst_i[2] = '{0, 0};
   int         byte_i[2]  = '{0, 0};
   logic [7:0] seed = '0;
   int         ready_mode = 0;   // 0 always ready, 1 random, 2 held low
   int         rx_dly = 1;       // 0 random 1..8, <0 never answer
   bit         spurious_en = 1'b0;
   int         pend = 0;
   logic [7:0] pend_byte = '0;
   logic [7:0] rx_val = '0;
   bit         rx_fire = 1'b0;
   int         cyc = 0;
   int         last_send_cyc = 0;
   int         last_done_cyc = 0;
   int         mdl_last = 1;

   int act_send[$], act_rx[$], act_done[$];
   int exp_send[$], exp_rx[$], exp_done[$];
   int ack_cnt[2] = '{0, 0};
   int exp_ack[2] = '{0, 0};

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [1:0] v);
      case (v)
         2'b01:   return 0;
         2'b10:   return 1;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] dat(input int i, input int b, input int k);
      return 8'(int'(seed) + i * 64 + b * 5 + k * 17);
   endfunction

   // requesters + SPI controller model; samples at negedge, drives at posedge+1
   initial begin
      int j;
      forever begin
         @(negedge clk);
         cyc++;
         rx_fire = 1'b0;
         if (!rst) begin
            pend = 0;
         end else begin
            if (spi_send) begin
               act_send.push_back(oh2i(grant) * 256 + int'(spi_tx_byte));
               chk("send_ss_n_low", int'(ss_n), 0);
               last_send_cyc = cyc;
               pend_byte = ~spi_tx_byte;
               pend = (rx_dly == 0) ? int'($urandom_range(8, 1)) : ((rx_dly < 0) ? 0 : rx_dly);
            end
            if (|rx_valid) act_rx.push_back(oh2i(rx_valid) * 256 + int'(rx_byte));
            for (int i = 0; i < 2; i++) begin
               if (byte_ack[i]) begin
                  ack_cnt[i]++;
                  byte_i[i]++;
               end
            end
            if (|done) begin
               j = oh2i(done);
               act_done.push_back(j);
               last_done_cyc = cyc;
`ifdef SPI_SCHED_TIMEOUT_EN
               last_err = err;
`endif
               if (j >= 0) begin
                  byte_i[j] = 0;
                  burst_i[j]++;
                  nb_left[j]--;
                  if (nb_left[j] <= 0) req_on[j] = 1'b0;
               end
            end
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  rx_fire = 1'b1;
                  rx_val  = pend_byte;
               end
            end else if (spurious_en && !spi_send && $urandom_range(15, 0) == 0) begin
               rx_fire = 1'b1;
               rx_val  = 8'($urandom);
            end
         end
         @(posedge clk);
         #1;
         spi_rx_dv   = rx_fire;
         spi_rx_byte = rx_fire ? rx_val : 8'h00;
         spi_ready   = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : 1'($urandom_range(1, 0));
         req         = req_on;
         for (int i = 0; i < 2; i++) begin
            req_len[i*LEN_W +: LEN_W] = LEN_W'(len_cfg[i]);
            req_tx_data[i*8 +: 8]     = dat(i, burst_i[i], byte_i[i]);
         end
      end
   end

   // builds the expected transcript from round-robin rules, then starts requests
   task automatic start_session(input logic [1:0] mask, input int l0, input int l1,
                                input int n0, input int n1, input logic [7:0] sd,
                                input int rmode, input int dly, input bit spur);
      int left[2];
      int bc[2];
      int w, n, c;
      logic [7:0] b, nb;
      exp_send.delete(); exp_rx.delete(); exp_done.delete();
      act_send.delete(); act_rx.delete(); act_done.delete();
      exp_ack = '{0, 0};
      ack_cnt = '{0, 0};
      seed    = sd;
      len_cfg = '{l0, l1};
      left[0] = mask[0] ? n0 : 0;
      left[1] = mask[1] ? n1 : 0;
      bc      = '{0, 0};
      nb_left = left;
      while (left[0] + left[1] > 0) begin
         w = -1;
         for (int k = 1; k <= 2; k++) begin
            c = (mdl_last + k) % 2;
            if (w < 0 && left[c] > 0) w = c;
         end
         n = (len_cfg[w] == 0) ? 1 : len_cfg[w];
         for (int k = 0; k < n; k++) begin
            b  = dat(w, bc[w], k);
            nb = ~b;
            exp_send.push_back(w * 256 + int'(b));
            exp_rx.push_back(w * 256 + int'(nb));
         end
         exp_ack[w] += n - 1;
         exp_done.push_back(w);
         left[w]--;
         bc[w]++;
         mdl_last = w;
      end
      burst_i     = '{0, 0};
      byte_i      = '{0, 0};
      ready_mode  = rmode;
      rx_dly      = dly;
      spurious_en = spur;
      req_on      = mask;
   endtask

   task automatic finish_session(input string nm);
      int t;
      t = 0;
      while (req_on != 2'b00 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_completed"}, int'(req_on), 0);
      repeat (3) @(negedge clk);
      chk({nm, "_nsend"}, act_send.size(), exp_send.size());
      chk({nm, "_ndone"}, act_done.size(), exp_done.size());
      chk({nm, "_nrx"}, act_rx.size(), exp_rx.size());
      for (int i = 0; i < exp_send.size() && i < act_send.size(); i++)
         chk($sformatf("%s_send%0d(owner*256+byte)", nm, i), act_send[i], exp_send[i]);
      for (int i = 0; i < exp_rx.size() && i < act_rx.size(); i++)
         chk($sformatf("%s_rx%0d(owner*256+byte)", nm, i), act_rx[i], exp_rx[i]);
      for (int i = 0; i < exp_done.size() && i < act_done.size(); i++)
         chk($sformatf("%s_done%0d", nm, i), act_done[i], exp_done[i]);
      chk({nm, "_ack0"}, ack_cnt[0], exp_ack[0]);
      chk({nm, "_ack1"}, ack_cnt[1], exp_ack[1]);
      chk({nm, "_ss_n_after"}, int'(ss_n), 1);
      chk({nm, "_grant_after"}, int'(grant), 0);
   endtask

   typedef struct packed {
      logic [1:0] mask;
      int         l0, l1, n0, n1;
      logic [7:0] sd;
      int         rmode, dly;
      bit         spur;
      int         exp_nsend;
      int         exp_first;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int t;
      int first;
      tbl[0] = '{2'b11, 1, 1, 2, 2, 8'h21, 0, 8, 1'b0, 4, 0};   // contention from reset
      tbl[1] = '{2'b01, 3, 0, 1, 0, 8'hA1, 0, 8, 1'b0, 3, 0};   // A1 B2 C3
      tbl[2] = '{2'b10, 0, 0, 0, 1, 8'h40, 0, 2, 1'b0, 1, 1};   // len 0 -> one byte
      tbl[3] = '{2'b11, 15, 2, 1, 3, 8'h07, 1, 0, 1'b1, 21, 0}; // max len mixed

      repeat (3) @(negedge clk);
      chk("rst_grant", int'(grant), 0);
      chk("rst_ss_n", int'(ss_n), 1);
      chk("rst_spi_send", int'(spi_send), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rx_valid", int'(rx_valid), 0);
      chk("rst_byte_ack", int'(byte_ack), 0);
      chk("rst_spi_tx_byte", int'(spi_tx_byte), 0);
      chk("rst_rx_byte", int'(rx_byte), 0);
      @(posedge clk);
      #2 rst = 1'b1;

      for (int v = 0; v < 4; v++) begin
         start_session(tbl[v].mask, tbl[v].l0, tbl[v].l1, tbl[v].n0, tbl[v].n1,
                       tbl[v].sd, tbl[v].rmode, tbl[v].dly, tbl[v].spur);
         finish_session($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_total_send", v), act_send.size(), tbl[v].exp_nsend);
         first = (act_done.size() > 0) ? act_done[0] : -1;
         chk($sformatf("vec%0d_first_grant", v), first, tbl[v].exp_first);
      end

      // backpressure: SEND must hold with spi_ready low
      start_session(2'b01, 1, 0, 1, 0, 8'h5A, 2, 3, 1'b0);
      repeat (20) @(negedge clk);
      chk("bp_no_send_while_not_ready", act_send.size(), 0);
      ready_mode = 0;
      finish_session("bp");

      for (int r = 0; r < 6; r++) begin
         start_session(2'($urandom_range(3, 1)), int'($urandom_range(15, 0)),
                       int'($urandom_range(15, 0)), int'($urandom_range(3, 1)),
                       int'($urandom_range(3, 1)), 8'($urandom), 1, 0, 1'b1);
         finish_session($sformatf("rnd%0d", r));
      end

      // reset in the middle of a 4-byte burst
      start_session(2'b01, 4, 0, 1, 0, 8'h10, 0, 3, 1'b0);
      t = 0;
      while (ack_cnt[0] < 1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("mid_rst_reached_byte1", ack_cnt[0], 1);
      @(negedge clk);
      chk("mid_rst_ss_n_before", int'(ss_n), 0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ss_n_async", int'(ss_n), 1);
      chk("mid_rst_grant_async", int'(grant), 0);
      req_on   = '0;
      mdl_last = 1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      start_session(2'b11, 2, 2, 1, 1, 8'h33, 0, 0, 1'b0);
      finish_session("post_rst");
      first = (act_done.size() > 0) ? act_done[0] : -1;
      chk("post_rst_first_grant", first, 0);

`ifdef SPI_SCHED_TIMEOUT_EN
      start_session(2'b01, 1, 0, 1, 0, 8'h55, 0, -1, 1'b0);
      t = 0;
      while (act_done.size() == 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("to_done_count", act_done.size(), 1);
      chk("to_send_to_done_cycles", last_done_cyc - last_send_cyc, 17);
      chk("to_err", int'(last_err), 1);
      @(negedge clk);
      chk("to_ss_n_after", int'(ss_n), 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_xfer_scheduler.md
Name: spi_xfer_scheduler

Overview:
- Round-robin arbiter and burst sequencer that shares the single SPI master controller (fsm_control_spi plus its shift datapath) among N_REQ requesters, e.g. the UART bridge and local register logic.
- Grants one requester at a time.
- Holds chip-select for that requester's whole multi-byte burst.
- Feeds TX bytes one at a time to the SPI controller and routes received bytes back to the granted requester.

Parameters:
N_REQ, 2, number of requesters (2..8)
LEN_W, 4, width of per-requester burst length field (max burst = 2^LEN_W-1 bytes)
TIMEOUT_CYC, 1024, WAIT-state watchdog limit in clk cycles (used only with optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  level request per requester; held until its done pulse
req_len  in  N_REQ*LEN_W  burst length in bytes per requester, slice i = [i*LEN_W +: LEN_W]
req_tx_data  in  N_REQ*8  current TX byte per requester, slice i = [i*8 +: 8]
grant  out  N_REQ  one-hot grant, high for entire burst
byte_ack  out  N_REQ  one-cycle pulse: granted requester's current TX byte consumed, present next
rx_byte  out  8  received byte, valid with rx_valid
rx_valid  out  N_REQ  one-hot one-cycle pulse to granted requester
done  out  N_REQ  one-cycle pulse at end of burst
ss_n  out  1  SPI chip-select, low during burst
spi_send  out  1  one-cycle start strobe to SPI controller
spi_tx_byte  out  8  byte to shift, stable from LOAD until next LOAD
spi_ready  in  1  SPI controller idle/ready (trans_ready)
spi_rx_dv  in  1  SPI controller received-byte valid pulse (i_RX_DV)
spi_rx_byte  in  8  SPI controller received byte

Behaviour:
- Reset (rst=0, async): state IDLE; grant=0, byte_ack=0, rx_valid=0, done=0, spi_send=0, spi_tx_byte=0, rx_byte=0; ss_n=1; byte_cnt=0; last_grant=N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ARB, LOAD, SEND, WAIT, DONE.
- IDLE: if |req, go to ARB.
- ARB (1 cycle):
  - Search starts at last_grant+1, modulo N_REQ; lowest index at or after that point wins.
  - Latch winner index and len. len=0 is treated as 1.
  - Assert grant one-hot and drive ss_n=0.
  - Go to LOAD.
- LOAD (1 cycle): spi_tx_byte <= winner's req_tx_data slice. Go to SEND.
- SEND:
  - If spi_ready=1: spi_send=1 for exactly this cycle, then WAIT.
  - If spi_ready=0: stay, spi_send=0.
- WAIT: on spi_rx_dv=1:
  - rx_byte <= spi_rx_byte; rx_valid[winner] pulses next cycle.
  - If byte_cnt==len-1: go to DONE.
  - Otherwise: byte_cnt++, byte_ack[winner] pulses, go to LOAD.
- DONE (1 cycle): done[winner]=1, ss_n=1, grant=0, byte_cnt=0, last_grant<=winner. Go to IDLE.
- Latency: ARB to first spi_send is 2 cycles minimum. There is a one-cycle IDLE gap between bursts, which guarantees ss_n high for at least 2 cycles.
- Requests that drop mid-burst are ignored; the burst completes.
- New requests during a burst wait for the next ARB.
- spi_rx_dv outside WAIT is ignored.
- spi_rx_dv and a timeout expiry in the same cycle: the data wins.
- Reset mid-burst: immediate return to reset values; ss_n=1 asynchronously.
- The last byte never generates byte_ack; it generates done.

Optional Feature:
Macro SPI_SCHED_TIMEOUT_EN.
- Defined:
  - Adds output err (N_REQ, one-hot pulse) and a counter that runs in WAIT, cleared on entering WAIT.
  - When the counter reaches TIMEOUT_CYC-1 with no spi_rx_dv: go to DONE. done and err for the winner pulse together, and the remaining bytes are abandoned.
- Undefined: no err port and no counter; WAIT waits indefinitely.

Decomposition:
- Package spi_sched_pkg:
  - state enum typedef sched_state_e (IDLE, ARB, LOAD, SEND, WAIT, DONE).
  - localparam MAX_REQ=8.
  - function for one-hot from index.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req, last_grant.
  - Outputs: winner index, any.
  - Reusable elsewhere.

Test Plan:
- Single burst: req=01, req_len[0]=3, data 0xA1/0xB2/0xC3, spi_ready=1, rx_dv 8 cycles after each send -> 3 spi_send pulses with bytes A1, B2, C3; 2 byte_ack[0]; 3 rx_valid[0]; done[0] once; ss_n low throughout, high after.
- Contention: req=11 from reset, both len=1 -> grant order 0,1,0,1 over 4 bursts; done alternates.
- Backpressure: spi_ready=0 for 20 cycles in SEND -> no spi_send until spi_ready=1, then exactly one pulse.
- len=0 on requester 1 -> exactly one byte sent, done[1].
- Reset assert mid-burst (after byte 1 of 4) -> ss_n=1 and grant=0 immediately; after release, a new burst starts from requester 0 with byte_cnt=0.
- With SPI_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, no rx_dv -> err[0] and done[0] pulse 16 cycles after WAIT entry, ss_n returns high.
